microsequencer: RTL and testbench
=================================

Name: microsequencer

Overview:
- Mic-1 style control unit; it is the initiator on the register-bank control interface.
- Holds a 512x36 control store, the MPC and the MIR, and issues one microinstruction per clock.
- Drives the register bank's C-bus write enables (c_select) and B-bus source select (b_select_encoded), plus ALU/shifter and memory strobes.
- Computes the next MPC from NEXT_ADDRESS, JAMN/JAMZ/JMPC, the ALU N/Z flags and MBR.

Parameters:
- CS_DEPTH, 512, control store words; the address is 9 bits.
- CS_WIDTH, 36, microinstruction width.
- CNT_WIDTH, 32, width of the executed-microinstruction counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  single-cycle pulse: begin execution at MPC=0 (accepted in LOAD or HALT only).
- ucode_we  in  1  control store write strobe; honoured only in LOAD or HALT.
- ucode_addr  in  9  control store write address.
- ucode_data  in  36  control store write data.
- alu_n  in  1  ALU result negative, valid in the current cycle.
- alu_z  in  1  ALU result zero, valid in the current cycle.
- mbr_data  in  8  MBR contents, used for JMPC.
- mem_wait  in  1  memory busy; stalls the sequencer.
- c_select  out  9  one-hot-per-bit C-bus write enables: [0]MAR [1]MDR [2]PC [3]SP [4]LV [5]CPP [6]TOS [7]OPC [8]H.
- b_select_encoded  out  4  B-bus source code, MIR[3:0].
- alu_ctrl  out  8  {SLL8,SRA1,F0,F1,ENA,ENB,INVA,INC}, MIR[23:16].
- mem_write  out  1  MIR[6].
- mem_read  out  1  MIR[5].
- mem_fetch  out  1  MIR[4].
- running  out  1  high in RUN.
- halted  out  1  high in HALT.
- ucycles  out  CNT_WIDTH  count of executed (non-stalled) microinstructions.

Behaviour:
- MIR layout: [35:27] NEXT_ADDRESS, [26] JMPC, [25] JAMN, [24] JAMZ, [23:16] ALU, [15:7] C, [6:4] MEM, [3:0] B.
- MEM=3'b111 is reserved as HALT.
- States:
  - LOAD is the reset state.
  - LOAD -> RUN on start.
  - RUN -> HALT on executing a HALT microinstruction.
  - HALT -> RUN on start.
- Reset (asynchronous):
  - state=LOAD, mpc=0, mir=0, ucycles=0.
  - All outputs are 0.
  - Control store contents are not cleared.
- Outputs in LOAD/HALT: c_select=0, b_select_encoded=0, alu_ctrl=0, mem_*=0.
- Outputs in RUN are combinational from the MIR, except:
  - during a stall, c_select=0 and mem_*=0; b_select_encoded and alu_ctrl still follow the MIR;
  - for a HALT microinstruction, c_select=0 and mem_*=0.
- start in LOAD/HALT: at the next posedge, mpc<=0, mir<=cs[0], state<=RUN. The first microinstruction is visible 1 cycle after the start pulse.
- start while in RUN is ignored.
- Next address, evaluated from the current MIR and live alu_n/alu_z/mbr_data:
  - na = NEXT_ADDRESS;
  - na[8] = NEXT_ADDRESS[8] | (JAMN & alu_n) | (JAMZ & alu_z);
  - if JMPC, na[7:0] = NEXT_ADDRESS[7:0] | mbr_data.
- Normal RUN posedge with mem_wait=0 and not HALT: mpc<=na, mir<=cs[na], ucycles<=ucycles+1. Throughput is 1 microinstruction per clock.
- Stall: mem_wait=1 in RUN holds mpc, mir and ucycles.
  - The MIR re-executes with full strobes in the first cycle after mem_wait falls.
  - Stall has priority over HALT.
- HALT microinstruction, not stalled: at the posedge, state<=HALT, ucycles<=ucycles+1, mpc and mir hold.
- ucycles wraps modulo 2^CNT_WIDTH without saturation.
- ucode_we in LOAD/HALT writes cs[ucode_addr]<=ucode_data at the posedge.
  - A write in the same cycle as start: the write lands first, then the fetch of cs[0] sees the new data (write-first).
  - ucode_we in RUN is ignored.
- B codes 9..15 pass through unchanged; the register bank drives nothing for them.
- Reset asserted mid-RUN returns immediately to LOAD with all outputs 0.

Decomposition:
- Shared package mic1_pkg:
  - MIR field bit positions;
  - MEM encodings, including HALT=3'b111;
  - B-bus codes: MDR=0, PC=1, MBR=2, MBRU=3, SP=4, LV=5, CPP=6, TOS=7, OPC=8;
  - C-bit indices and ALU function constants.
- Shared by the register bank, ALU and this block.
- One combinational sub-module, mic1_next_addr (MIR fields, n, z, mbr -> 9-bit na), so the next-address rule is verified in isolation.
- The control store array stays in the top module.

Test Plan:
- Load cs[0]={na=9'h005, C=9'h100, B=4'd1, ALU=8'h3C} and cs[5]=HALT, then pulse start.
  - Cycle 1: c_select=9'h100, b_select_encoded=1, alu_ctrl=8'h3C.
  - Cycle 2: all strobes 0.
  - Then halted=1 and ucycles=2.
- JAMZ branch: cs[0] na=9'h010 with JAMZ=1 and alu_z=1 -> next MIR fetched from cs[9'h110]. The same with alu_z=0 -> cs[9'h010].
- JMPC dispatch: cs[0] na=9'h100 with JMPC=1, mbr_data=8'h36 -> next MPC=9'h136.
- Stall: cs[0] MEM=3'b010 (read), mem_wait=1 for 3 cycles.
  - mem_read=0 and c_select=0 while stalled; mpc holds and ucycles holds.
  - After release, mem_read=1 for one cycle, then the sequencer advances.
- Reset mid-RUN:
  - assert reset between clock edges -> outputs 0 and running=0 immediately;
  - control store retained, so start re-executes cs[0] unchanged.
- ucode_we during RUN with addr=0 is ignored: after HALT and restart, the original cs[0] is executed.

Source files
------------

// File: rtl/mic1_pkg.sv
// Shared Mic-1 definitions: microinstruction field layout, memory/B-bus/C-bus
// encodings and the sequencer state type, used by the sequencer, register bank and ALU.
package mic1_pkg;

    localparam int MIR_NA_LSB  = 27;
    localparam int MIR_JMPC    = 26;
    localparam int MIR_JAMN    = 25;
    localparam int MIR_JAMZ    = 24;
    localparam int MIR_ALU_LSB = 16;
    localparam int MIR_C_LSB   = 7;
    localparam int MIR_MEM_LSB = 4;
    localparam int MIR_B_LSB   = 0;

    // MEM field is {WRITE, READ, FETCH}; all three set together is not a real access.
    localparam logic [2:0] MEM_NONE  = 3'b000;
    localparam logic [2:0] MEM_FETCH = 3'b001;
    localparam logic [2:0] MEM_READ  = 3'b010;
    localparam logic [2:0] MEM_WRITE = 3'b100;
    localparam logic [2:0] MEM_HALT  = 3'b111;

    localparam logic [3:0] B_MDR  = 4'd0;
    localparam logic [3:0] B_PC   = 4'd1;
    localparam logic [3:0] B_MBR  = 4'd2;
    localparam logic [3:0] B_MBRU = 4'd3;
    localparam logic [3:0] B_SP   = 4'd4;
    localparam logic [3:0] B_LV   = 4'd5;
    localparam logic [3:0] B_CPP  = 4'd6;
    localparam logic [3:0] B_TOS  = 4'd7;
    localparam logic [3:0] B_OPC  = 4'd8;

    localparam int C_MAR = 0;
    localparam int C_MDR = 1;
    localparam int C_PC  = 2;
    localparam int C_SP  = 3;
    localparam int C_LV  = 4;
    localparam int C_CPP = 5;
    localparam int C_TOS = 6;
    localparam int C_OPC = 7;
    localparam int C_H   = 8;

    // ALU {F0,F1} function select
    localparam logic [1:0] ALU_F_AND  = 2'b00;
    localparam logic [1:0] ALU_F_OR   = 2'b01;
    localparam logic [1:0] ALU_F_NOTB = 2'b10;
    localparam logic [1:0] ALU_F_ADD  = 2'b11;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } seq_state_e;

endpackage

// File: rtl/mic1_next_addr.sv
// Mic-1 next-microinstruction address: JAMN/JAMZ OR into bit 8, JMPC ORs MBR into the low byte.
module mic1_next_addr (
    input  logic [8:0] next_address,
    input  logic       jmpc,
    input  logic       jamn,
    input  logic       jamz,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic [7:0] mbr_data,
    output logic [8:0] na
);

    always_comb begin
        na    = next_address;
        na[8] = next_address[8] | (jamn & alu_n) | (jamz & alu_z);
        if (jmpc) begin
            na[7:0] = next_address[7:0] | mbr_data;
        end
    end

endmodule

// File: rtl/microsequencer.sv
// Mic-1 control unit: control store, MPC and MIR; issues one microinstruction per
// clock and drives the register-bank, ALU and memory control strobes.
module microsequencer
    import mic1_pkg::*;
#(
    parameter int CS_DEPTH  = 512,
    parameter int CS_WIDTH  = 36,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 ucode_we,
    input  logic [8:0]           ucode_addr,
    input  logic [CS_WIDTH-1:0]  ucode_data,
    input  logic                 alu_n,
    input  logic                 alu_z,
    input  logic [7:0]           mbr_data,
    input  logic                 mem_wait,
    output logic [8:0]           c_select,
    output logic [3:0]           b_select_encoded,
    output logic [7:0]           alu_ctrl,
    output logic                 mem_write,
    output logic                 mem_read,
    output logic                 mem_fetch,
    output logic                 running,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] ucycles
);

    logic [CS_WIDTH-1:0]  cs_mem [CS_DEPTH];

    seq_state_e           state_q, state_d;
    logic [8:0]           mpc_q, mpc_d;
    logic [CS_WIDTH-1:0]  mir_q, mir_d;
    logic [CNT_WIDTH-1:0] ucycles_q, ucycles_d;

    logic                 run, idle, is_halt, strobe_en, cs_we;
    logic [8:0]           na, fetch_addr;
    logic [CS_WIDTH-1:0]  cs_rd;
    logic [2:0]           mir_mem;

    assign run       = (state_q == ST_RUN);
    assign idle      = (state_q == ST_LOAD) || (state_q == ST_HALT);
    assign mir_mem   = mir_q[MIR_MEM_LSB +: 3];
    assign is_halt   = (mir_mem == MEM_HALT);
    assign strobe_en = run && !mem_wait && !is_halt;
    assign cs_we     = ucode_we && idle;

    mic1_next_addr u_next_addr (
        .next_address (mir_q[MIR_NA_LSB +: 9]),
        .jmpc         (mir_q[MIR_JMPC]),
        .jamn         (mir_q[MIR_JAMN]),
        .jamz         (mir_q[MIR_JAMZ]),
        .alu_n        (alu_n),
        .alu_z        (alu_z),
        .mbr_data     (mbr_data),
        .na           (na)
    );

    // Single read port: a stalled or halting MIR simply re-reads its own MPC.
    always_comb begin
        fetch_addr = '0;
        if (run) begin
            fetch_addr = (mem_wait || is_halt) ? mpc_q : na;
        end
    end

    assign cs_rd = cs_mem[fetch_addr];

    always_ff @(posedge clock) begin
        if (cs_we) begin
            cs_mem[ucode_addr] <= ucode_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        mpc_d     = mpc_q;
        mir_d     = mir_q;
        ucycles_d = ucycles_q;
        case (state_q)
            ST_LOAD, ST_HALT: begin
                if (start) begin
                    state_d = ST_RUN;
                    mpc_d   = '0;
                    // A same-cycle write to word 0 must be what the first fetch sees.
                    mir_d   = (cs_we && (ucode_addr == 9'd0)) ? ucode_data : cs_rd;
                end
            end
            ST_RUN: begin
                if (!mem_wait) begin
                    ucycles_d = ucycles_q + CNT_WIDTH'(1);
                    if (is_halt) begin
                        state_d = ST_HALT;
                    end else begin
                        mpc_d = na;
                        mir_d = cs_rd;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_LOAD;
            mpc_q     <= '0;
            mir_q     <= '0;
            ucycles_q <= '0;
        end else begin
            state_q   <= state_d;
            mpc_q     <= mpc_d;
            mir_q     <= mir_d;
            ucycles_q <= ucycles_d;
        end
    end

    assign c_select                         = strobe_en ? mir_q[MIR_C_LSB +: 9] : 9'd0;
    assign {mem_write, mem_read, mem_fetch} = strobe_en ? mir_mem : MEM_NONE;
    assign b_select_encoded                 = run ? mir_q[MIR_B_LSB +: 4] : 4'd0;
    assign alu_ctrl                         = run ? mir_q[MIR_ALU_LSB +: 8] : 8'd0;
    assign running                          = run;
    assign halted                           = (state_q == ST_HALT);
    assign ucycles                          = ucycles_q;

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for the Mic-1 microsequencer with a scoreboard of expected strobes.
module tb_microsequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        ucode_we = 1'b0;
    logic [8:0]  ucode_addr = '0;
    logic [35:0] ucode_data = '0;
    logic        alu_n = 1'b0;
    logic        alu_z = 1'b0;
    logic [7:0]  mbr_data = '0;
    logic        mem_wait = 1'b0;

    logic [8:0]  c_select;
    logic [3:0]  b_select_encoded;
    logic [7:0]  alu_ctrl;
    logic        mem_write, mem_read, mem_fetch;
    logic        running, halted;
    logic [31:0] ucycles;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic [8:0] c;
        logic [3:0] b;
        logic [7:0] alu;
        logic [2:0] mem;
        logic       run;
        logic       halt;
    } exp_t;

    exp_t sb[$];

    microsequencer dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .ucode_we         (ucode_we),
        .ucode_addr       (ucode_addr),
        .ucode_data       (ucode_data),
        .alu_n            (alu_n),
        .alu_z            (alu_z),
        .mbr_data         (mbr_data),
        .mem_wait         (mem_wait),
        .c_select         (c_select),
        .b_select_encoded (b_select_encoded),
        .alu_ctrl         (alu_ctrl),
        .mem_write        (mem_write),
        .mem_read         (mem_read),
        .mem_fetch        (mem_fetch),
        .running          (running),
        .halted           (halted),
        .ucycles          (ucycles)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [35:0] mi(input logic [8:0] na, input logic jmpc, input logic jamn,
                                       input logic jamz, input logic [7:0] alu, input logic [8:0] c,
                                       input logic [2:0] mem, input logic [3:0] b);
        return {na, jmpc, jamn, jamz, alu, c, mem, b};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [8:0] c, input logic [3:0] b,
                              input logic [7:0] alu, input logic [2:0] mem,
                              input logic run, input logic halt);
        exp_t e;
        e.tag = tag; e.c = c; e.b = b; e.alu = alu; e.mem = mem; e.run = run; e.halt = halt;
        sb.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".c_select"}, 64'(c_select), 64'(e.c));
            chk({e.tag, ".b_select"}, 64'(b_select_encoded), 64'(e.b));
            chk({e.tag, ".alu_ctrl"}, 64'(alu_ctrl), 64'(e.alu));
            chk({e.tag, ".mem"}, 64'({mem_write, mem_read, mem_fetch}), 64'(e.mem));
            chk({e.tag, ".running"}, 64'(running), 64'(e.run));
            chk({e.tag, ".halted"}, 64'(halted), 64'(e.halt));
        end
    endtask

    task automatic edge_check();
        @(posedge clock);
        #1;
        compare_front();
    endtask

    task automatic cs_write(input logic [8:0] a, input logic [35:0] d);
        ucode_addr = a;
        ucode_data = d;
        ucode_we   = 1'b1;
        @(posedge clock);
        #1;
        ucode_we   = 1'b0;
    endtask

    initial begin
        // reset state
        #2;
        expect_out("reset", 9'h0, 4'h0, 8'h00, 3'b000, 1'b0, 1'b0);
        compare_front();
        chk("reset.ucycles", 64'(ucycles), 64'd0);
        @(posedge clock);
        #2;
        reset = 1'b0;

        // basic: one microinstruction then HALT
        cs_write(9'h000, mi(9'h005, 1'b0, 1'b0, 1'b0, 8'h3C, 9'h100, 3'b000, 4'd1));
        cs_write(9'h005, mi(9'h000, 1'b0, 1'b0, 1'b0, 8'h00, 9'h000, 3'b111, 4'd0));
        chk("load.running", 64'(running), 64'd0);
        start = 1'b1;
        expect_out("basic.c1", 9'h100, 4'd1, 8'h3C, 3'b000, 1'b1, 1'b0);
        edge_check();
        start = 1'b0;
        expect_out("basic.c2", 9'h000, 4'd0, 8'h00, 3'b000, 1'b1, 1'b0);
        edge_check();
        expect_out("basic.halt", 9'h000, 4'd0, 8'h00, 3'b000, 1'b0, 1'b1);
        edge_check();
        chk("basic.ucycles", 64'(ucycles), 64'd2);

        // JAMZ branch, taken then not taken
        cs_write(9'h000, mi(9'h010, 1'b0, 1'b0, 1'b1, 8'h11, 9'h000, 3'b000, 4'd2));
        cs_write(9'h110, mi(9'h005, 1'b0, 1'b0, 1'b0, 8'hAA, 9'h001, 3'b000, 4'd3));
        cs_write(9'h010, mi(9'h005, 1'b0, 1'b0, 1'b0, 8'h55, 9'h002, 3'b000, 4'd4));
        for (int k = 0; k < 2; k++) begin
            alu_z = (k == 0);
            start = 1'b1;
            expect_out("jamz.c1", 9'h000, 4'd2, 8'h11, 3'b000, 1'b1, 1'b0);
            edge_check();
            start = 1'b0;
            if (k == 0) expect_out("jamz.taken", 9'h001, 4'd3, 8'hAA, 3'b000, 1'b1, 1'b0);
            else        expect_out("jamz.fall", 9'h002, 4'd4, 8'h55, 3'b000, 1'b1, 1'b0);
            edge_check();
            alu_z = 1'b0;
            expect_out("jamz.haltmi", 9'h000, 4'd0, 8'h00, 3'b000, 1'b1, 1'b0);
            edge_check();
            expect_out("jamz.halted", 9'h000, 4'd0, 8'h00, 3'b000, 1'b0, 1'b1);
            edge_check();
        end
        chk("jamz.ucycles", 64'(ucycles), 64'd8);

        // JMPC dispatch, with cs[0] rewritten in the same cycle as start
        cs_write(9'h136, mi(9'h005, 1'b0, 1'b0, 1'b0, 8'h77, 9'h040, 3'b001, 4'd7));
        mbr_data   = 8'h36;
        ucode_addr = 9'h000;
        ucode_data = mi(9'h100, 1'b1, 1'b0, 1'b0, 8'h01, 9'h000, 3'b000, 4'd0);
        ucode_we   = 1'b1;
        start      = 1'b1;
        expect_out("jmpc.writefirst", 9'h000, 4'd0, 8'h01, 3'b000, 1'b1, 1'b0);
        edge_check();
        ucode_we = 1'b0;
        start    = 1'b0;
        expect_out("jmpc.dispatch", 9'h040, 4'd7, 8'h77, 3'b001, 1'b1, 1'b0);
        edge_check();
        mbr_data = 8'h00;
        expect_out("jmpc.haltmi", 9'h000, 4'd0, 8'h00, 3'b000, 1'b1, 1'b0);
        edge_check();
        expect_out("jmpc.halted", 9'h000, 4'd0, 8'h00, 3'b000, 1'b0, 1'b1);
        edge_check();
        chk("jmpc.ucycles", 64'(ucycles), 64'd11);

        // memory stall on a read microinstruction
        cs_write(9'h000, mi(9'h005, 1'b0, 1'b0, 1'b0, 8'h22, 9'h001, 3'b010, 4'd1));
        start = 1'b1;
        expect_out("stall.first", 9'h001, 4'd1, 8'h22, 3'b010, 1'b1, 1'b0);
        edge_check();
        start    = 1'b0;
        mem_wait = 1'b1;
        #1;
        expect_out("stall.wait0", 9'h000, 4'd1, 8'h22, 3'b000, 1'b1, 1'b0);
        compare_front();
        for (int k = 0; k < 2; k++) begin
            expect_out("stall.waitn", 9'h000, 4'd1, 8'h22, 3'b000, 1'b1, 1'b0);
            edge_check();
            chk("stall.ucycles_hold", 64'(ucycles), 64'd11);
        end
        mem_wait = 1'b0;
        #1;
        expect_out("stall.release", 9'h001, 4'd1, 8'h22, 3'b010, 1'b1, 1'b0);
        compare_front();
        expect_out("stall.advance", 9'h000, 4'd0, 8'h00, 3'b000, 1'b1, 1'b0);
        edge_check();
        chk("stall.ucycles_adv", 64'(ucycles), 64'd12);
        expect_out("stall.halted", 9'h000, 4'd0, 8'h00, 3'b000, 1'b0, 1'b1);
        edge_check();
        chk("stall.ucycles_end", 64'(ucycles), 64'd13);

        // looping program, ignored RUN-time write, then reset mid-RUN
        cs_write(9'h000, mi(9'h001, 1'b0, 1'b0, 1'b0, 8'h3C, 9'h100, 3'b000, 4'd5));
        cs_write(9'h001, mi(9'h001, 1'b0, 1'b0, 1'b0, 8'h81, 9'h080, 3'b000, 4'hF));
        start = 1'b1;
        expect_out("loop.c0", 9'h100, 4'd5, 8'h3C, 3'b000, 1'b1, 1'b0);
        edge_check();
        start = 1'b0;
        expect_out("loop.c1", 9'h080, 4'hF, 8'h81, 3'b000, 1'b1, 1'b0);
        edge_check();
        ucode_addr = 9'h000;
        ucode_data = mi(9'h005, 1'b0, 1'b0, 1'b0, 8'hEE, 9'h1FF, 3'b000, 4'd9);
        ucode_we   = 1'b1;
        start      = 1'b1;
        expect_out("loop.c2", 9'h080, 4'hF, 8'h81, 3'b000, 1'b1, 1'b0);
        edge_check();
        ucode_we = 1'b0;
        start    = 1'b0;
        chk("loop.ucycles", 64'(ucycles), 64'd15);
        #3;
        reset = 1'b1;
        #1;
        expect_out("midreset", 9'h000, 4'd0, 8'h00, 3'b000, 1'b0, 1'b0);
        compare_front();
        chk("midreset.ucycles", 64'(ucycles), 64'd0);
        #1;
        reset = 1'b0;
        start = 1'b1;
        expect_out("restart.cs0", 9'h100, 4'd5, 8'h3C, 3'b000, 1'b1, 1'b0);
        edge_check();
        start = 1'b0;

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
